// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencer for the 5-stage MIPS core, sitting beside the ID-stage
// control decoder. It stalls the front end on load-use hazards, flushes
// wrong-path instructions after a taken branch/jump, and freezes the whole
// pipeline while a data-memory access is outstanding (with a timeout abort).
//
// State table:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_RUN      | normal flow; load-use stall and branch flush handled here
//   S_FLUSH    | discarding wrong-path instructions for FLUSH_CYCLES-1 more
//   S_MEM_WAIT | data-memory handshake outstanding, pipeline frozen
//
// Parameters:
//   FLUSH_CYCLES  cycles of ifid_flush/idex_bubble after a taken branch (1..15)
//   MEM_TIMEOUT   max consecutive stalled memory cycles before abort (2..65535)
//   CNT_W         width of the saturating stall counter
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_op_code, id_rs, id_rt   fields of the instruction in ID
//   ex_mem_read, ex_rt         MemRead and destination of the instruction in EX
//   branch_taken               branch/jump resolved taken (level)
//   mem_req, mem_ready         data-memory handshake of the MEM stage
//   pc_write .. memwb_write    pipeline register write enables
//   ifid_flush, idex_bubble,
//   exmem_bubble               NOP insertion controls
//   mem_error                  sticky memory timeout flag
//   stall_count                saturating count of cycles with pc_write=0
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_op_code,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST    = 16'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             release_q, release_d;
  logic             mem_error_q, mem_error_d;
  logic [CNT_W-1:0] stall_count_q;

  logic id_uses_rt;
  logic load_use;
  logic mem_stall;

  // Opcodes that read rt as a source: R-type, BEQ, BNE, SB, SH, SW.
  always_comb begin
    id_uses_rt = 1'b0;
    case (id_op_code)
      6'b000000, 6'b000100, 6'b000101,
      6'b101000, 6'b101001, 6'b101011: id_uses_rt = 1'b1;
      default:                         id_uses_rt = 1'b0;
    endcase
  end

  assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = 16'd0;
    release_d    = 1'b0;
    mem_error_d  = mem_error_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    memwb_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;

    // A pending forced release overrides a still-stalled memory so the
    // pipeline cannot stay frozen forever after a timeout.
    if (mem_stall && !release_q) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      state_d     = S_MEM_WAIT;
      if (wait_cnt_q == WAIT_LAST) begin
        mem_error_d = 1'b1;
        release_d   = 1'b1;
        wait_cnt_d  = 16'd0;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end else begin
      // The aborted access left garbage control bits heading into EX/MEM.
      exmem_bubble = release_q;
      if (state_q == S_FLUSH) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (branch_taken) begin
          flush_cnt_d = FLUSH_RELOAD;
        end else if (flush_cnt_q <= 4'd1) begin
          flush_cnt_d = 4'd0;
          state_d     = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end else if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_RELOAD;
        end else begin
          state_d     = S_RUN;
          flush_cnt_d = 4'd0;
        end
      end else begin
        state_d     = S_RUN;
        flush_cnt_d = 4'd0;
        if (load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
    end

    // Reset must show idle controls immediately, even with a stalled memory.
    if (!rst_n) begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      idex_write   = 1'b1;
      exmem_write  = 1'b1;
      memwb_write  = 1'b1;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      flush_cnt_q   <= 4'd0;
      wait_cnt_q    <= 16'd0;
      release_q     <= 1'b0;
      mem_error_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      release_q   <= release_d;
      mem_error_q <= mem_error_d;
      if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
        stall_count_q <= stall_count_q + 1'b1;
      end
    end
  end

  assign mem_error   = mem_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed-vector bench. Each step drives one cycle of inputs and queues the
// hand-computed outputs for that cycle; a monitor on the falling edge pops the
// queue and compares the DUT outputs against it.
// Control bundle order: {pc_write, ifid_write, idex_write, exmem_write,
//                        memwb_write, ifid_flush, idex_bubble, exmem_bubble}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [7:0] RUN_V = 8'b11111_000;
  localparam logic [7:0] LU_V  = 8'b00111_010;
  localparam logic [7:0] BR_V  = 8'b11111_111;
  localparam logic [7:0] FL_V  = 8'b11111_110;
  localparam logic [7:0] MS_V  = 8'b00000_000;
  localparam logic [7:0] TO_V  = 8'b11111_001;

  logic             clk;
  logic             rst_n;
  logic [5:0]       id_op_code;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_bubble;
  logic             mem_error;
  logic [CNT_W-1:0] stall_count;

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(3),
    .MEM_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_op_code  (id_op_code),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_write  (idex_write),
    .exmem_write (exmem_write),
    .memwb_write (memwb_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .exmem_bubble(exmem_bubble),
    .mem_error   (mem_error),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            nm;
    logic [7:0]       ctl;
    logic             me;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected for that cycle.
  task automatic step(input string nm, input logic r,
                      input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic emr, input logic [4:0] ert, input logic br,
                      input logic mreq, input logic mrdy,
                      input logic [7:0] ctl, input logic me, input logic [CNT_W-1:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = r;
    id_op_code   = op;
    id_rs        = rs;
    id_rt        = rt;
    ex_mem_read  = emr;
    ex_rt        = ert;
    branch_taken = br;
    mem_req      = mreq;
    mem_ready    = mrdy;
    e.nm  = nm;
    e.ctl = ctl;
    e.me  = me;
    e.sc  = sc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
             ifid_flush, idex_bubble, exmem_bubble};
      n_vec++;
      if (act !== e.ctl || mem_error !== e.me || stall_count !== e.sc) begin
        n_err++;
        $display("FAIL %s: got ctl=%b mem_error=%b stall_count=%0d, want ctl=%b mem_error=%b stall_count=%0d",
                 e.nm, act, mem_error, stall_count, e.ctl, e.me, e.sc);
      end
    end
  end

  initial begin
    int guard;
    rst_n        = 1'b0;
    id_op_code   = 6'd0;
    id_rs        = 5'd0;
    id_rt        = 5'd0;
    ex_mem_read  = 1'b0;
    ex_rt        = 5'd0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
    repeat (3) @(posedge clk);

    //   name             rst op         rs  rt  emr ert br  req rdy  ctl    me  sc
    step("reset_idle",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  0);
    step("lu_rtype_rt",    1, 6'b000000,  1,  5, 1,  5, 0,  0,  0,  LU_V,  0,  0);
    step("lu_cleared",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  1);
    step("lu_rt_zero",     1, 6'b000000,  0,  0, 1,  0, 0,  0,  0,  RUN_V, 0,  1);
    step("addi_rt_dest",   1, 6'b001000,  3,  7, 1,  7, 0,  0,  0,  RUN_V, 0,  1);
    step("sw_rt_src",      1, 6'b101011,  3,  7, 1,  7, 0,  0,  0,  LU_V,  0,  1);
    step("sw_cleared",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  2);
    step("lu_rs",          1, 6'b001000,  9,  2, 1,  9, 0,  0,  0,  LU_V,  0,  2);
    step("br_first",       1, 6'b000000,  0,  0, 0,  0, 1,  0,  0,  BR_V,  0,  3);
    step("br_flush2_lu",   1, 6'b000000,  1,  5, 1,  5, 0,  0,  0,  FL_V,  0,  3);
    step("br_flush3_lu",   1, 6'b000000,  1,  5, 1,  5, 0,  0,  0,  FL_V,  0,  3);
    step("br_done",        1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  3);
    step("mw_1",           1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  0,  3);
    step("mw_2",           1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  0,  4);
    step("mw_3",           1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  0,  5);
    step("mw_4",           1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  0,  6);
    step("mw_release",     1, 6'b000000,  0,  0, 0,  0, 0,  1,  1,  RUN_V, 0,  7);
    step("mw_after",       1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  7);
    step("mwbr_1",         1, 6'b000000,  0,  0, 0,  0, 1,  1,  0,  MS_V,  0,  7);
    step("mwbr_2",         1, 6'b000000,  0,  0, 0,  0, 1,  1,  0,  MS_V,  0,  8);
    step("mwbr_release",   1, 6'b000000,  0,  0, 0,  0, 1,  1,  1,  BR_V,  0,  9);
    step("mwbr_flush2",    1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  FL_V,  0,  9);
    step("mwbr_flush3",    1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  FL_V,  0,  9);
    step("mwbr_done",      1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  9);
    step("rl_first",       1, 6'b000000,  0,  0, 0,  0, 1,  0,  0,  BR_V,  0,  9);
    step("rl_reload",      1, 6'b000000,  0,  0, 0,  0, 1,  0,  0,  FL_V,  0,  9);
    step("rl_flush_a",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  FL_V,  0,  9);
    step("rl_flush_b",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  FL_V,  0,  9);
    step("rl_done",        1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  9);
    for (int k = 0; k < 8; k++) begin
      step($sformatf("to_stall_%0d", k + 1),
                           1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  0,  CNT_W'(9 + k));
    end
    step("to_release",     1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  TO_V,  1, 17);
    step("to_run",         1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 1, 17);
    step("to_sticky",      1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 1, 17);
    step("pre_rst_mw1",    1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  1, 17);
    step("pre_rst_mw2",    1, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  MS_V,  1, 18);
    step("async_reset",    0, 6'b000000,  0,  0, 0,  0, 0,  1,  0,  RUN_V, 0,  0);
    step("post_reset",     1, 6'b000000,  0,  0, 0,  0, 0,  0,  0,  RUN_V, 0,  0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 5-stage MIPS core. It sits beside the ID-stage control decoder.
- Detects load-use hazards and stalls the front end.
- On a taken branch or jump, flushes wrong-path instructions for a programmable number of cycles.
- Freezes the whole pipeline while the data memory handshake is outstanding, with a timeout.
- Outputs drive the pipeline-register write enables and the bubble select that forces the decoder outputs to all-zero (NOP).

Parameters:
FLUSH_CYCLES, 1, cycles ifid_flush/idex_bubble stay asserted after a taken branch (1..15)
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before abort (2..65535)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
id_op_code  in  6  opcode of instruction in ID
id_rs  in  5  rs field in ID
id_rt  in  5  rt field in ID
ex_mem_read  in  1  MemRead of instruction in EX
ex_rt  in  5  destination rt of instruction in EX
branch_taken  in  1  branch/jump resolved taken (MEM stage), level
mem_req  in  1  MEM stage instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
idex_write  out  1  ID/EX register enable
exmem_write  out  1  EX/MEM register enable
memwb_write  out  1  MEM/WB register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  force decoder outputs to zero into ID/EX
exmem_bubble  out  1  clear control bits entering EX/MEM
mem_error  out  1  sticky: memory timeout occurred
stall_count  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- States: RUN, FLUSH, MEM_WAIT. Reset → RUN, flush_cnt=0, wait_cnt=0, mem_error=0, stall_count=0.
- Reset values of the all-combinational outputs in RUN with no hazard: all *_write=1, all flush/bubble=0.
- Registered outputs: mem_error, stall_count.
- id_uses_rt = 1 when id_op_code ∈ {000000, 000100, 000101, 101000, 101001, 101011}; 0 otherwise.
- load_use = ex_mem_read & (ex_rt≠0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)). Evaluated combinationally, same cycle.
- mem_stall = mem_req & ~mem_ready.
- Priority, evaluated each cycle: mem_stall > branch_taken/FLUSH > load_use.
- mem_stall (any state):
  - All five *_write=0; all flush/bubble=0.
  - Next state MEM_WAIT; wait_cnt increments.
  - branch_taken is ignored while frozen. Upstream holds it stable; it is acted on in the release cycle.
- MEM_WAIT with mem_ready=1 or mem_req=0:
  - Acts as RUN in that cycle, including branch handling.
  - wait_cnt clears.
- MEM_WAIT timeout: when wait_cnt reaches MEM_TIMEOUT-1 while still stalled:
  - Set mem_error=1 (sticky until reset).
  - Next cycle forces release: memwb_write=1, exmem_bubble=1 for one cycle, wait_cnt clears, state RUN.
- branch_taken in RUN/MEM_WAIT release, no mem_stall:
  - ifid_flush=1, idex_bubble=1, exmem_bubble=1; pc_write=1 so the target is loaded.
  - If FLUSH_CYCLES>1: go to FLUSH with flush_cnt=FLUSH_CYCLES-1.
- FLUSH:
  - ifid_flush=1, idex_bubble=1, exmem_bubble=0, pc_write=1.
  - flush_cnt decrements; at 1 → RUN.
  - load_use is ignored in FLUSH: the ID instruction is being discarded.
  - A new branch_taken in FLUSH reloads flush_cnt=FLUSH_CYCLES-1.
- load_use in RUN, no branch, no mem_stall:
  - pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble.
  - Next cycle the load is in MEM, so the hazard clears naturally. No extra state.
- stall_count increments on every cycle with pc_write=0 and saturates at all-ones.
- Reset asserted mid-operation: immediate return to reset values. In-flight flush/wait counts are discarded.

Test Plan:
- Reset: rst_n=0 mid-MEM_WAIT → state RUN, all *_write=1, mem_error=0, stall_count=0, asynchronously before the next clk edge.
- Load-use: ex_mem_read=1, ex_rt=5, id_op_code=000000, id_rt=5 → exactly 1 cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1. Same case with ex_rt=0 → no stall.
- LW followed by ADDI using rt of the load as destination only (id_op_code=001000, id_rt=ex_rt=7, id_rs=3) → no stall.
- Branch with FLUSH_CYCLES=3: branch_taken for 1 cycle → ifid_flush=1 and idex_bubble=1 for 3 cycles; exmem_bubble=1 only in the first; pc_write=1 throughout. A load_use during cycles 2-3 is ignored.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 → all *_write=0 for 4 cycles, stall_count=4. Concurrent branch_taken causes flush only in the release cycle.
- Timeout with MEM_TIMEOUT=8: mem_ready held 0 → mem_error rises after 8 stalled cycles; a one-cycle exmem_bubble release follows, and mem_error stays 1 until rst_n=0.
